// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch FIFO between I-memory fetch and decode.
// Optional build macro FETCH_QUEUE_BYPASS_EN enables the empty-queue in->out bypass.
// Head entry is presented with opcode and all immediate formats pre-extracted.

// Purpose: DEPTH-entry circular FIFO of {instr, pc} with decode-ready immediates.
// Latency: 1 cycle push-to-head (0 cycles on the bypass path when enabled).
// Backpressure: in_ready drops when full (no pop-through); flush discards everything.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_pc,
  output logic [6:0]       opcode,
  output logic [31:0]      imm_i,
  output logic [31:0]      imm_s,
  output logic [31:0]      imm_b,
  output logic [31:0]      imm_u,
  output logic [31:0]      imm_j,
  output logic [31:0]      imm_z,
  output logic [CNT_W-1:0] count
);

  localparam int          PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic [31:0]      instr_mem [DEPTH];
  logic [31:0]      pc_mem    [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             bypass;
  logic             push;
  logic             pop;
  logic             wr_en;
  logic             rd_adv;
  logic [31:0]      head_instr;

  // Handshake qualification; a bypassed-and-consumed entry never touches storage.
  always_comb begin
    in_ready  = (count_q != CNT_W'(DEPTH));
`ifdef FETCH_QUEUE_BYPASS_EN
    bypass    = (count_q == '0) & in_valid & ~flush;
`else
    bypass    = 1'b0;
`endif
    out_valid = (count_q != '0) | bypass;
    push      = in_valid & in_ready & ~flush;
    pop       = out_valid & out_ready & ~flush;
    wr_en     = push & ~(bypass & out_ready);
    rd_adv    = pop & ~bypass;
  end

  // Pointer and occupancy next-state; flush wins over any push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en)  wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_adv) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({wr_en, rd_adv})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; intentionally not reset, contents are qualified by count.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      instr_mem[wr_ptr_q] <= in_instr;
      pc_mem[wr_ptr_q]    <= in_pc;
    end
  end

  // Head selection with NOP gating when nothing is valid.
  always_comb begin
    head_instr = NOP;
    out_pc     = '0;
    if (bypass) begin
      head_instr = in_instr;
      out_pc     = in_pc;
    end else if (out_valid) begin
      head_instr = instr_mem[rd_ptr_q];
      out_pc     = pc_mem[rd_ptr_q];
    end
  end

  // Pre-decode of every immediate format from the head instruction.
  always_comb begin
    out_instr = head_instr;
    opcode    = head_instr[6:0];
    imm_i     = {{20{head_instr[31]}}, head_instr[31:20]};
    imm_s     = {{20{head_instr[31]}}, head_instr[31:25], head_instr[11:7]};
    imm_b     = {{19{head_instr[31]}}, head_instr[31], head_instr[7],
                 head_instr[30:25], head_instr[11:8], 1'b0};
    imm_u     = {head_instr[31:12], 12'b0};
    imm_j     = {{11{head_instr[31]}}, head_instr[31], head_instr[19:12],
                 head_instr[20], head_instr[30:21], 1'b0};
    imm_z     = {27'b0, head_instr[19:15]};
  end

  assign count = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios plus randomized traffic against a queue-based model.
module tb_fetch_queue;

  localparam int          DEPTH = 4;
  localparam int          CNT_W = $clog2(DEPTH) + 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [31:0]      in_pc;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic [31:0]      out_pc;
  logic [6:0]       opcode;
  logic [31:0]      imm_i, imm_s, imm_b, imm_u, imm_j, imm_z;
  logic [CNT_W-1:0] count;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .opcode(opcode), .imm_i(imm_i), .imm_s(imm_s), .imm_b(imm_b), .imm_u(imm_u),
    .imm_j(imm_j), .imm_z(imm_z), .count(count)
  );

  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] mq[$];          // model contents, {instr, pc}, head at index 0

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Sign-extend the low 'bits' bits of v.
  function automatic logic [31:0] sx(input logic [31:0] v, input int bits);
    logic signed [31:0] t;
    t = v << (32 - bits);
    return t >>> (32 - bits);
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] x, input int kind);
    case (kind)
      0: return sx(x >> 20, 12);
      1: return sx(((x >> 25) << 5) | ((x >> 7) & 32'd31), 12);
      2: return sx((((x >> 31) & 32'd1) << 12) | (((x >> 7) & 32'd1) << 11) |
                   (((x >> 25) & 32'd63) << 5) | (((x >> 8) & 32'd15) << 1), 13);
      3: return x & 32'hFFFF_F000;
      4: return sx((((x >> 31) & 32'd1) << 20) | (((x >> 12) & 32'd255) << 12) |
                   (((x >> 20) & 32'd1) << 11) | (((x >> 21) & 32'd1023) << 1), 21);
      default: return (x >> 15) & 32'd31;
    endcase
  endfunction

  // One clock: drive, compare all outputs against the model, then advance the model.
  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic ordy, input logic fl, output logic accepted);
    logic        byp, ov, ir, pu, po;
    logic [63:0] head;
    logic [31:0] ei, ep;
    @(negedge clock);
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
    #1;
    byp  = BYP && (mq.size() == 0) && v && !fl;
    ov   = (mq.size() != 0) || byp;
    ir   = (mq.size() < DEPTH);
    head = byp ? {ins, pc} : ((mq.size() != 0) ? mq[0] : 64'h0);
    ei   = ov ? head[63:32] : NOP;
    ep   = ov ? head[31:0] : 32'h0;
    check("out_valid", 32'(out_valid), 32'(ov));
    check("in_ready",  32'(in_ready),  32'(ir));
    check("count",     32'(count),     32'(mq.size()));
    check("out_instr", out_instr, ei);
    check("out_pc",    out_pc,    ep);
    check("opcode",    32'(opcode), ei & 32'h7F);
    check("imm_i", imm_i, ref_imm(ei, 0));
    check("imm_s", imm_s, ref_imm(ei, 1));
    check("imm_b", imm_b, ref_imm(ei, 2));
    check("imm_u", imm_u, ref_imm(ei, 3));
    check("imm_j", imm_j, ref_imm(ei, 4));
    check("imm_z", imm_z, ref_imm(ei, 5));
    pu = v && ir && !fl;
    po = ov && ordy && !fl;
    accepted = pu;
    @(posedge clock);
    if (fl) mq.delete();
    else if (!(byp && ordy)) begin
      if (po) void'(mq.pop_front());
      if (pu) mq.push_back({ins, pc});
    end
  endtask

  // Park inputs idle and sample at mid-cycle for explicit constant checks.
  task automatic peek();
    @(negedge clock);
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    #1;
  endtask

  logic        acc;
  logic [31:0] pend[$];

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 32'h0; in_pc = 32'h0;
    #12;
    check("rst_count", 32'(count), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_instr", out_instr, NOP);
    @(negedge clock);
    reset = 1'b0;

    // First push and one-cycle visibility
    step(1'b1, 32'h0050_0093, 32'h100, 1'b0, 1'b0, acc);
    peek();
    check("tp1_out_valid", 32'(out_valid), 32'd1);
    check("tp1_out_pc", out_pc, 32'h100);
    check("tp1_opcode", 32'(opcode), 32'h13);
    check("tp1_imm_i", imm_i, 32'd5);
    check("tp1_count", 32'(count), 32'd1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);

    // Fill to full, then a rejected fifth push
    for (int i = 0; i < 4; i++) step(1'b1, $urandom, 32'(i * 4), 1'b0, 1'b0, acc);
    peek();
    check("full_count", 32'(count), 32'd4);
    check("full_in_ready", 32'(in_ready), 32'd0);
    step(1'b1, $urandom, 32'h10, 1'b0, 1'b0, acc);
    check("full_reject", 32'(acc), 32'd0);
    peek();
    check("full_count_hold", 32'(count), 32'd4);

    // Drain with wrap-around while feeding two more
    pend.push_back(32'h10); pend.push_back(32'h14);
    for (int i = 0; i < 6; i++) begin
      if (pend.size() != 0) begin
        step(1'b1, $urandom, pend[0], 1'b1, 1'b0, acc);
        if (acc) void'(pend.pop_front());
      end else step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
    end
    peek();
    check("drain_count", 32'(count), 32'd0);

    // Flush with a simultaneous push
    step(1'b1, $urandom, 32'h300, 1'b0, 1'b0, acc);
    step(1'b1, $urandom, 32'h304, 1'b0, 1'b0, acc);
    step(1'b1, $urandom, 32'h308, 1'b0, 1'b1, acc);
    peek();
    check("flush_count", 32'(count), 32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_out_instr", out_instr, NOP);

    // Immediate formats on known encodings
    step(1'b1, 32'hFE00_0EE3, 32'h400, 1'b0, 1'b0, acc);
    peek();
    check("beq_imm_b", imm_b, 32'hFFFF_FFFC);
    check("beq_opcode", 32'(opcode), 32'h63);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
    step(1'b1, 32'h8000_00EF, 32'h404, 1'b0, 1'b0, acc);
    peek();
    check("jal_imm_j", imm_j, 32'hFFF0_0000);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
    step(1'b1, 32'h3400_D073, 32'h408, 1'b0, 1'b0, acc);
    peek();
    check("csr_imm_z", imm_z, 32'd1);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);

    // Empty queue, offer and consume in the same cycle
    step(1'b1, 32'h0010_0113, 32'h200, 1'b1, 1'b0, acc);
    peek();
    check("byp_count", 32'(count), BYP ? 32'd0 : 32'd1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, acc);

    // Asynchronous reset in the middle of a cycle
    step(1'b1, $urandom, 32'h500, 1'b0, 1'b0, acc);
    step(1'b1, $urandom, 32'h504, 1'b0, 1'b0, acc);
    @(negedge clock);
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("arst_count", 32'(count), 32'd0);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    mq.delete();
    @(negedge clock);
    reset = 1'b0;

    // Randomized traffic with alternating fill/drain bias
    for (int i = 0; i < 600; i++) begin
      logic v, r, f;
      if ((i / 50) % 2 == 0) begin
        v = ($urandom_range(0, 3) != 0);
        r = ($urandom_range(0, 3) == 0);
      end else begin
        v = ($urandom_range(0, 3) == 0);
        r = ($urandom_range(0, 3) != 0);
      end
      f = ($urandom_range(0, 39) == 0);
      step(v, $urandom, $urandom, r, f, acc);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
